load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, meaning 1 = misaligned access rejected with rsp_err and 0 = address low bits forced to natural alignment.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  misaligned or illegal funct3; qualified by rsp_valid.
REQ-013 dmem_we  output  1  word write enable to data_mem.
REQ-014 dmem_addr  output  32  word-aligned address, bits[1:0] = 00.
REQ-015 dmem_wd  output  32  full word to write.
REQ-016 dmem_rd  input  32  data_mem combinational read of dmem_addr.

Function
REQ-017 The handshake SHALL occur on a rising edge with req_valid && req_ready; request fields are registered then and ignored afterwards.
REQ-018 The FSM SHALL have states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-019 Funct3 encodings SHALL be 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all other loads and store funct3 >= 011 SHALL be illegal.
REQ-020 Error requests SHALL go IDLE->RESP with rsp_err=1; dmem_we SHALL never assert; rsp_valid SHALL be in cycle t+1 after accept at t.
REQ-021 Errors are: illegal funct3, or ALIGN_CHECK=1 with a halfword at addr[0]=1 or a word at addr[1:0]!=00.
REQ-022 Loads SHALL go IDLE->LOAD->RESP: LOAD drives dmem_addr and registers the lane-selected, sign/zero-extended data; rsp_valid in t+2.
REQ-023 SW SHALL go IDLE->WRITE->RESP with dmem_we=1 and dmem_wd=req_wdata in WRITE; rsp_valid in t+2.
REQ-024 SB/SH SHALL go IDLE->RMW_RD->WRITE->RESP: RMW_RD registers dmem_rd, WRITE writes that word with only the addressed byte/halfword lane replaced; rsp_valid in t+3.
REQ-025 Byte lane SHALL be addr[1:0]; halfword lane SHALL be addr[1]; little-endian.
REQ-026 dmem_we SHALL be 1 only in WRITE; dmem_addr SHALL hold the registered word address in every non-IDLE state.
REQ-027 RESP SHALL last exactly one cycle and then return to IDLE; a back-to-back accept SHALL be possible in the following cycle.
REQ-028 req_valid asserted while req_ready=0 SHALL have no effect.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dmem_we=0, dmem_addr=0, dmem_wd=0.
REQ-030 Reset during RMW_RD or WRITE SHALL abort the request with no response, and no write SHALL occur on the following edge.

Structure
REQ-031 Package lsu_pkg SHALL hold the funct3 localparams, the FSM state encoding, and the word-align mask.
REQ-032 Combinational lane extract/extend and lane merge SHALL live in sub-module lsu_lane_mux; FSM and registers SHALL live in load_store_unit.

Verification
REQ-033 Bench SHALL instantiate data_mem with 10 ns clk.
- SW 0xDEADBEEF @0x0, then LW @0x0 -> dmem_we for one cycle; rsp_rdata=0xDEADBEEF; rsp_valid 2 cycles after accept.
- SW 0xCAFEBABE @0x4; SB 0xAA @0x5 -> word@4=0xCAFEAABE, rsp_valid at t+3; LBU @0x5 -> 0x000000AA; LB @0x5 -> 0xFFFFFFAA.
- SW 0xCAFEBABE @0x4; SH 0x1234 @0x6 -> word@4=0x1234BABE; LH @0x4 -> 0xFFFFBABE; LHU @0x6 -> 0x00001234.
- LW @0x2 and SH @0x5 (ALIGN_CHECK=1); load funct3=011 -> rsp_err=1 at t+1, rsp_rdata=0, dmem_we never high.
- SB 0x55 @0x8 over 0x11223344, reset_n low mid-WRITE before edge -> dmem_we falls at once, word@8 stays 0x11223344, req_ready=1 after release.
- req_valid held high across an SB -> exactly one transaction per RESP; second request accepted the cycle after RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: funct3 codes,
// FSM encoding and address helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Lane extract/extend for loads and lane merge for
// partial stores; little-endian byte ordering.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [31:0] sh;
  logic [15:0] half;
  logic        sx;

  always_comb begin
    sh   = word >> {off, 3'b000};
    half = off[1] ? word[31:16] : word[15:0];
    sx   = ~funct3[2];
    ld_data = word;
    case (funct3[1:0])
      2'b00:   ld_data = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   ld_data = {{16{sx & half[15]}}, half};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    st_word = word;
    case (funct3[1:0])
      2'b00: st_word[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) st_word[31:16] = wdata[15:0];
        else        st_word[15:0]  = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time,
// partial stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  logic [2:0]  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;

  logic        legal;
  logic        mis;
  logic        bad;
  logic [1:0]  off_in;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  lsu_lane_mux u_lane (
    .funct3  (f3_q),
    .off     (off_q),
    .word    (dmem_rd),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_comb begin
    legal = f3_legal(req_we, req_funct3);
    mis   = (ALIGN_CHECK != 0) &&
            (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
             ((req_funct3[1:0] == 2'b10) &&
              (req_addr[1:0] != 2'b00)));
    bad   = !legal || mis;
    // Lane offset snapped to natural alignment when unchecked.
    case (req_funct3[1:0])
      2'b01:   off_in = {req_addr[1], 1'b0};
      2'b10:   off_in = 2'b00;
      default: off_in = req_addr[1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          off_d   = off_in;
          addr_d  = req_addr & WORD_MASK;
          wdata_d = req_wdata;
          err_d   = bad;
          buf_d   = '0;
          if (bad)
            state_d = S_RESP;
          else if (!req_we)
            state_d = S_LOAD;
          else if (req_funct3 == F3_W) begin
            buf_d   = req_wdata;
            state_d = S_WRITE;
          end else
            state_d = S_RMW_RD;
        end
      end
      state_q == S_LOAD: begin
        buf_d   = ld_data;
        state_d = S_RESP;
      end
      state_q == S_RMW_RD: begin
        buf_d   = st_word;
        state_d = S_WRITE;
      end
      state_q == S_WRITE: begin
        buf_d   = '0;
        state_d = S_RESP;
      end
      state_q == S_RESP: begin
        buf_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? buf_q : '0;
  assign dmem_we   = (state_q == S_WRITE);
  assign dmem_addr = req_ready ? '0 : addr_q;
  assign dmem_wd   = dmem_we ? buf_q : '0;

endmodule
